// File: rtl/fixedtofloat_pkg.sv
// rtl/fixedtofloat_pkg.sv - shared types and float-format constants for the fixed-to-float block
//
// Purpose: sequencer state encoding and IEEE-754 single-precision field sizes.
package fixedtofloat_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    LZC,
    NORM,
    ROUND,
    PACK
  } state_t;

  localparam int FLT_BIAS   = 127;
  localparam int FLT_EXP_W  = 8;
  localparam int FLT_MANT_W = 23;

endpackage

// File: rtl/clz32.sv
// rtl/clz32.sv - combinational 32-bit leading-zero counter
//
// Purpose: counts leading zeros of a 32-bit word, returning 32 for an all-zero word.
// Ports:
//   value  in   32  word to examine
//   count  out   6  number of leading zeros, 0..32
module clz32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  // Scan from the LSB upward so the highest set bit wins last.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) begin
        count = 6'(31 - i);
      end
    end
  end

endmodule

// File: rtl/fixedtofloat_jrt.sv
// rtl/fixedtofloat_jrt.sv - signed fixed-point to IEEE-754 single converter, run_req/run_busy method
//
// Purpose: six-step sequencer (IDLE, ABS, LZC, NORM, ROUND, PACK) converting a signed
//          Q(31-FRAC_BITS).FRAC_BITS word to a float with round-to-nearest-even.
// Ports:
//   clock            in    1  system clock
//   reset_n          in    1  asynchronous active-low reset
//   ce               in    1  clock enable; all state frozen while low
//   i_run_req        in    1  conversion request, sampled only while idle
//   o_run_busy       out   1  high while a conversion is in progress
//   o_run_return     out  32  float result, held until the next completion
//   i_run_input_a_0  in   32  signed fixed-point operand
module fixedtofloat_jrt
  import fixedtofloat_pkg::*;
#(
  parameter int FRAC_BITS = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        i_run_req,
  output logic        o_run_busy,
  output logic [31:0] o_run_return,
  input  logic [31:0] i_run_input_a_0
);

  // Exponent of a value whose top set bit sits at position 31 of the magnitude.
  localparam logic [8:0] EXP_BASE = 9'(FLT_BIAS + 31 - FRAC_BITS);

  state_t state_q, state_d;

  logic [31:0]           a_q;
  logic                  sign_q;
  logic [31:0]           mag_q;
  logic [5:0]            lz_q;
  logic                  zero_q;
  logic [30:0]           norm_q;     // bit 31 of the normalised word is the implicit one
  logic [8:0]            exp_q;
  logic [FLT_MANT_W-1:0] mant_q;
  logic [31:0]           ret_q;

  logic [5:0]  lz_count;
  logic [32:0] neg_a;
  logic        round_up;
  logic [23:0] mant_sum;

  clz32 u_clz32 (
    .value (mag_q),
    .count (lz_count)
  );

  // 33-bit negate so that -(2^31) yields a magnitude of 2^31 rather than wrapping.
  assign neg_a    = 33'd0 - {a_q[31], a_q};
  assign round_up = norm_q[7] & ((|norm_q[6:0]) | norm_q[8]);
  assign mant_sum = {1'b0, norm_q[30:8]} + {23'd0, round_up};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_run_req) state_d = ABS;
      ABS:     state_d = LZC;
      LZC:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = PACK;
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      lz_q    <= '0;
      zero_q  <= 1'b0;
      norm_q  <= '0;
      exp_q   <= '0;
      mant_q  <= '0;
      ret_q   <= '0;
    end else if (ce) begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (i_run_req) a_q <= i_run_input_a_0;
        end
        ABS: begin
          sign_q <= a_q[31];
          mag_q  <= a_q[31] ? neg_a[31:0] : a_q;
        end
        LZC: begin
          lz_q   <= lz_count;
          zero_q <= (mag_q == 32'd0);
        end
        NORM: begin
          norm_q <= 31'(mag_q << lz_q);
          exp_q  <= EXP_BASE - {3'b000, lz_q};
        end
        ROUND: begin
          // A carry out of the 23-bit field means the mantissa rolled to 1.0 of the next binade.
          if (mant_sum[23]) begin
            mant_q <= '0;
            exp_q  <= exp_q + 9'd1;
          end else begin
            mant_q <= mant_sum[22:0];
          end
        end
        PACK: begin
          ret_q <= zero_q ? 32'h0 : {sign_q, exp_q[FLT_EXP_W-1:0], mant_q};
        end
        default: ;
      endcase
    end
  end

  assign o_run_busy   = (state_q != IDLE);
  assign o_run_return = ret_q;

endmodule

// File: tb/tb_fixedtofloat_jrt.sv
// tb/tb_fixedtofloat_jrt.sv - self-checking bench for fixedtofloat_jrt
module tb_fixedtofloat_jrt;

  localparam int FRAC = 16;

  logic        clock;
  logic        reset_n;
  logic        ce;
  logic        i_run_req;
  logic        o_run_busy;
  logic [31:0] o_run_return;
  logic [31:0] i_run_input_a_0;

  int checks = 0;
  int errors = 0;

  fixedtofloat_jrt #(.FRAC_BITS(FRAC)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ce              (ce),
    .i_run_req       (i_run_req),
    .o_run_busy      (o_run_busy),
    .o_run_return    (o_run_return),
    .i_run_input_a_0 (i_run_input_a_0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Value-level reference: real value = a / 2^FRAC, rounded to 24 significant bits, ties to even.
  function automatic logic [31:0] ref_conv(input logic [31:0] a);
    longint v, m, q, rem, half, e;
    int     p, drop;
    logic   s;
    logic [31:0] r;
    v = longint'($signed(a));
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) return 32'h0;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      drop = p - 23;
      q    = m >> drop;
      rem  = m - (q << drop);
      half = longint'(1) << (drop - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    e = 127 + p - FRAC;
    r = {s, e[7:0], q[22:0]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [31:0] a);
    i_run_input_a_0 = a;
    i_run_req = 1'b1;
    tick();
    i_run_req = 1'b0;
  endtask

  // Counts edges after the current point until busy drops; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (o_run_busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic conv(input string tag, input logic [31:0] a, input logic [31:0] exp);
    int n;
    start(a);
    wait_idle(n);
    check({tag, "_lat"}, 32'(n), 32'd5);
    check(tag, o_run_return, exp);
  endtask

  initial begin
    int n;
    logic [31:0] a, b;

    reset_n = 1'b0;
    ce = 1'b1;
    i_run_req = 1'b0;
    i_run_input_a_0 = 32'h0;
    #12;
    check("rst_busy", {31'd0, o_run_busy}, 32'd0);
    check("rst_ret", o_run_return, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // 1.0 with cycle-by-cycle busy/return observation
    start(32'h00010000);
    check("one_busy_e0", {31'd0, o_run_busy}, 32'd1);
    check("one_ret_e0", o_run_return, 32'h0);
    for (int k = 1; k < 5; k++) begin
      tick();
      check("one_busy_mid", {31'd0, o_run_busy}, 32'd1);
      check("one_ret_mid", o_run_return, 32'h0);
    end
    tick();
    check("one_busy_e5", {31'd0, o_run_busy}, 32'd0);
    check("one_ret", o_run_return, 32'h3F800000);

    // Directed values
    conv("neg1p5", 32'hFFFE8000, 32'hBFC00000);
    conv("zero", 32'h00000000, 32'h00000000);
    conv("minint", 32'h80000000, 32'hC7000000);
    conv("maxcarry", 32'h7FFFFFFF, 32'h47000000);
    conv("tie_even", 32'h01000001, 32'h43800000);
    conv("tie_odd", 32'h01000003, ref_conv(32'h01000003));
    conv("tiny", 32'h00000001, 32'h37800000);

    // Request while busy is ignored
    a = 32'h00054321;
    b = 32'hDEADBEEF;
    start(a);
    tick();
    i_run_input_a_0 = b;
    i_run_req = 1'b1;
    tick();
    i_run_req = 1'b0;
    wait_idle(n);
    check("ign_lat", 32'(n), 32'd3);
    check("ign_ret", o_run_return, ref_conv(a));
    tick();
    check("ign_no_restart", {31'd0, o_run_busy}, 32'd0);

    // Request held high: second conversion begins the edge after busy falls
    a = 32'hFFF00001;
    b = 32'h12345678;
    i_run_input_a_0 = a;
    i_run_req = 1'b1;
    tick();
    wait_idle(n);
    check("hold_lat1", 32'(n), 32'd5);
    check("hold_ret1", o_run_return, ref_conv(a));
    i_run_input_a_0 = b;
    tick();
    check("hold_restart", {31'd0, o_run_busy}, 32'd1);
    i_run_req = 1'b0;
    wait_idle(n);
    check("hold_lat2", 32'(n), 32'd5);
    check("hold_ret2", o_run_return, ref_conv(b));

    // ce low for three cycles while in NORM
    a = 32'hFF123457;
    start(a);
    tick();
    tick();
    ce = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("ce_frozen_busy", {31'd0, o_run_busy}, 32'd1);
    ce = 1'b1;
    wait_idle(n);
    check("ce_lat", 32'(n + 5), 32'd8);
    check("ce_ret", o_run_return, ref_conv(a));

    // Asynchronous reset in ROUND
    start(32'h00030000);
    tick();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, o_run_busy}, 32'd0);
    check("arst_ret", o_run_return, 32'h0);
    #2;
    reset_n = 1'b1;
    tick();
    conv("after_rst", 32'h00010000, 32'h3F800000);

    // Randomised values across a wide magnitude range
    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      a = 32'($signed(a) >>> $urandom_range(0, 31));
      if (k % 13 == 0) a = 32'h0;
      conv("rand", a, ref_conv(a));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
